dc_reload_sequencer: RTL and testbench

DC_RELOAD_SEQUENCER -- requirements
Module: dc_reload_sequencer

---
 rtl/dc_reload_sequencer.sv | 130 +++++++++++++
 tb/tb_dc_reload_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_reload_sequencer.sv
// Reloads stale DC slots from memory one at a time: grant, read request, wait, write strobe.
// Optional macro DC_RELOAD_RR_EN selects a round-robin grant instead of fixed lowest-index priority.
module dc_reload_sequencer #(
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [3:0]                 reload_req,
    input  logic [3:0][WORD_WIDTH-1:0] dc_addrs,
    output logic                       mem_req,
    output logic [WORD_WIDTH-1:0]      mem_addr,
    input  logic                       mem_ack,
    input  logic                       mem_valid,
    input  logic [WORD_WIDTH-1:0]      mem_data,
    output logic                       dc_reload,
    output logic [1:0]                 dc_mutate,
    output logic [WORD_WIDTH-1:0]      dc_data,
    output logic [3:0]                 pending,
    output logic                       busy
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StWrite} state_e;

    state_e                state_q, state_d;
    logic [3:0]            pending_q, pending_d, pending_clr;
    logic [1:0]            slot_q, slot_d;
    logic [WORD_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic                  grant_valid;
    logic [1:0]            grant_slot;

`ifdef DC_RELOAD_RR_EN
    logic [1:0] last_q, last_d;
    logic [1:0] cand;

    // Search starts one past the most recently granted slot.
    always_comb begin
        grant_valid = 1'b0;
        grant_slot  = 2'd0;
        cand        = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = last_q + 2'(k + 1);
            if (!grant_valid && pending_q[cand]) begin
                grant_valid = 1'b1;
                grant_slot  = cand;
            end
        end
    end
`else
    always_comb begin
        grant_valid = |pending_q;
        grant_slot  = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (pending_q[k]) begin
                grant_slot = 2'(k);
            end
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        pending_clr = 4'b0000;
        slot_d      = slot_q;
        addr_d      = addr_q;
        data_d      = data_q;
`ifdef DC_RELOAD_RR_EN
        last_d      = last_q;
`endif
        case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    pending_clr[grant_slot] = 1'b1;
                    slot_d                  = grant_slot;
                    addr_d                  = dc_addrs[grant_slot];
                    state_d                 = StReq;
`ifdef DC_RELOAD_RR_EN
                    last_d                  = grant_slot;
`endif
                end
            end
            StReq: begin
                if (mem_ack) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (mem_valid) begin
                    data_d  = mem_data;
                    state_d = StWrite;
                end
            end
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // New requests win over the grant clear for the same slot.
        pending_d = (pending_q & ~pending_clr) | reload_req;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            pending_q <= 4'b0000;
            slot_q    <= 2'd0;
            addr_q    <= '0;
            data_q    <= '0;
`ifdef DC_RELOAD_RR_EN
            last_q    <= 2'd3;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            slot_q    <= slot_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
`ifdef DC_RELOAD_RR_EN
            last_q    <= last_d;
`endif
        end
    end

    assign mem_req   = (state_q == StReq);
    assign mem_addr  = addr_q;
    assign dc_reload = (state_q == StWrite);
    assign dc_mutate = slot_q;
    assign dc_data   = data_q;
    assign pending   = pending_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_dc_reload_sequencer.sv
// Randomized plus directed bench for dc_reload_sequencer against a transaction-level model.
// Honours DC_RELOAD_RR_EN the same way as the design.
module tb_dc_reload_sequencer;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        reload_req;
    logic [3:0][31:0]  dc_addrs;
    logic              mem_req;
    logic [31:0]       mem_addr;
    logic              mem_ack;
    logic              mem_valid;
    logic [31:0]       mem_data;
    logic              dc_reload;
    logic [1:0]        dc_mutate;
    logic [31:0]       dc_data;
    logic [3:0]        pending;
    logic              busy;

    dc_reload_sequencer #(.WORD_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .reload_req (reload_req),
        .dc_addrs   (dc_addrs),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_valid  (mem_valid),
        .mem_data   (mem_data),
        .dc_reload  (dc_reload),
        .dc_mutate  (dc_mutate),
        .dc_data    (dc_data),
        .pending    (pending),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int served[$];

    // Transaction-level model: one fetch in flight, step 1=request, 2=await data, 3=write.
    logic [3:0]  m_pend;
    bit          m_busy;
    int          m_step;
    int          m_slot;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    int          m_last;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int pick(input logic [3:0] p, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (p[(last + k) % 4]) return (last + k) % 4;
        end
        return 0;
    endfunction

    task automatic model_update();
        logic [3:0] np;
        int s;
        if (reset) begin
            m_pend = 4'b0; m_busy = 0; m_step = 0; m_slot = 0;
            m_addr = '0;   m_data = '0; m_last = 3;
        end else begin
            np = m_pend;
            if (!m_busy) begin
                if (m_pend != 4'b0) begin
                    s      = pick(m_pend, m_last);
                    np[s]  = 1'b0;
                    m_slot = s;
                    m_addr = dc_addrs[s];
                    m_busy = 1;
                    m_step = 1;
`ifdef DC_RELOAD_RR_EN
                    m_last = s;
`endif
                end
            end else if (m_step == 1) begin
                if (mem_ack) m_step = 2;
            end else if (m_step == 2) begin
                if (mem_valid) begin
                    m_data = mem_data;
                    m_step = 3;
                end
            end else begin
                m_busy = 0;
                m_step = 0;
            end
            m_pend = np | reload_req;
        end
    endtask

    task automatic compare();
        check_eq("busy",      32'(busy),      32'(m_busy));
        check_eq("pending",   32'(pending),   32'(m_pend));
        check_eq("mem_req",   32'(mem_req),   32'(m_busy && m_step == 1));
        check_eq("mem_addr",  mem_addr,       m_addr);
        check_eq("dc_reload", 32'(dc_reload), 32'(m_busy && m_step == 3));
        check_eq("dc_mutate", 32'(dc_mutate), 32'(m_slot));
        check_eq("dc_data",   dc_data,        m_data);
    endtask

    // Inputs are set at the falling edge before calling; outputs are checked at the next one.
    task automatic cycle();
        model_update();
        @(posedge clk);
        @(negedge clk);
        compare();
        if (dc_reload) served.push_back(int'(dc_mutate));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; reload_req = 4'b0; dc_addrs = '0;
        mem_ack = 1'b0; mem_valid = 1'b0; mem_data = '0;
        do_reset();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_addr", mem_addr, 32'd0);

        // Single fetch with immediate ack and data.
        mem_ack = 1'b1; mem_valid = 1'b1; mem_data = 32'hDEADBEEF;
        dc_addrs[2] = 32'h100;
        reload_req = 4'b0100;
        cycle();
        reload_req = 4'b0;
        check_eq("r034_pend", 32'(pending), 32'h4);
        cycle();
        check_eq("r034_req",  32'(mem_req), 32'd1);
        check_eq("r034_addr", mem_addr, 32'h100);
        cycle();
        cycle();
        check_eq("r034_rel",  32'(dc_reload), 32'd1);
        check_eq("r034_slot", 32'(dc_mutate), 32'd2);
        check_eq("r034_data", dc_data, 32'hDEADBEEF);
        check_eq("r034_pend0", 32'(pending), 32'd0);
        cycle();

        // All four slots at once, then 1001 after slot 0 was served.
        served.delete();
        reload_req = 4'b1111;
        cycle();
        reload_req = 4'b0;
        repeat (20) cycle();
        check_eq("r035_cnt", 32'(served.size()), 32'd4);
        for (int i = 0; i < 4 && i < served.size(); i++) check_eq("r035_order", served[i], i);
        do_reset();
        served.delete();
        reload_req = 4'b0001;
        cycle();
        reload_req = 4'b0;
        repeat (6) cycle();
        reload_req = 4'b1001;
        cycle();
        reload_req = 4'b0;
        repeat (12) cycle();
        check_eq("r035_cnt2", 32'(served.size()), 32'd3);
        if (served.size() == 3) begin
`ifdef DC_RELOAD_RR_EN
            check_eq("r035_rr1", served[1], 32'd3);
            check_eq("r035_rr2", served[2], 32'd0);
`else
            check_eq("r035_fp1", served[1], 32'd0);
            check_eq("r035_fp2", served[2], 32'd3);
`endif
        end

        // Ack withheld: request and address held while the slot address moves.
        mem_ack = 1'b0;
        dc_addrs[0] = 32'h40;
        reload_req = 4'b0001;
        cycle();
        reload_req = 4'b0;
        cycle();
        for (int i = 0; i < 5; i++) begin
            dc_addrs[0] = 32'h200;
            cycle();
            check_eq("r036_req",  32'(mem_req), 32'd1);
            check_eq("r036_addr", mem_addr, 32'h40);
        end
        mem_ack = 1'b1;
        repeat (4) cycle();

        // Re-request of the in-flight slot yields a second fetch at the new address.
        served.delete();
        mem_valid = 1'b0;
        dc_addrs[0] = 32'h300;
        reload_req = 4'b0001;
        cycle();
        reload_req = 4'b0;
        cycle();
        cycle();
        dc_addrs[0] = 32'h380;
        reload_req = 4'b0001;
        cycle();
        reload_req = 4'b0;
        cycle();
        mem_valid = 1'b1;
        repeat (10) cycle();
        check_eq("r037_cnt",  32'(served.size()), 32'd2);
        check_eq("r037_addr", mem_addr, 32'h380);

        // Reset during the data wait abandons the fetch and drops pending work.
        mem_valid = 1'b0;
        reload_req = 4'b0001;
        cycle();
        reload_req = 4'b0;
        cycle();
        cycle();
        reload_req = 4'b0110;
        cycle();
        check_eq("r038_pend", 32'(pending), 32'h6);
        reload_req = 4'b1000;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        reload_req = 4'b0;
        check_eq("r038_busy", 32'(busy), 32'd0);
        check_eq("r038_pend0", 32'(pending), 32'd0);
        served.delete();
        mem_valid = 1'b1;
        repeat (5) cycle();
        check_eq("r038_stray", 32'(served.size()), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            reload_req = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            mem_ack    = 1'($urandom);
            mem_valid  = 1'($urandom);
            mem_data   = $urandom;
            if ($urandom_range(0, 3) == 0) dc_addrs[$urandom_range(0, 3)] = $urandom;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
